// File: rtl/td4_sequencer.sv
// TD4 instruction sequencer: fetch/decode/exec around an external ALU.
// cur_o/next_i layout is {carry, out[3:0], pc[3:0], b[3:0], a[3:0]}; opecode_o is ir[7:4] for valid codes, 4'h8 for INVALID.
module td4_sequencer #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        step_i,
  output logic        rom_en_o,
  output logic [3:0]  rom_addr_o,
  input  logic [7:0]  rom_data_i,
  output logic [3:0]  opecode_o,
  output logic [3:0]  imm_o,
  output logic [16:0] cur_o,
  input  logic [16:0] next_i,
  output logic [3:0]  out_port_o,
  output logic        busy_o,
  output logic        retired_o
);
  localparam logic [3:0] OP_INVALID = 4'h8;
  localparam logic [7:0] TICK_LAST  = 8'(TICK_DIV - 1);

  typedef struct packed {
    logic       carry;
    logic [3:0] out;
    logic [3:0] pc;
    logic [3:0] b;
    logic [3:0] a;
  } regs_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC} state_e;

  state_e     state_q, state_d;
  regs_t      cur_q, cur_d, nxt;
  logic [7:0] ir_q, ir_d;
  logic [7:0] tick_cnt_q, tick_cnt_d;
  logic       tick, start, op_valid;
  logic [3:0] op_dec;

  assign nxt        = regs_t'(next_i);
  assign cur_o      = cur_q;
  assign out_port_o = cur_q.out;

  // Tick counter free-runs; a tick seen outside IDLE is simply lost.
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? 8'd0 : tick_cnt_q + 8'd1;
  assign start      = run_i ? tick : step_i;

  assign op_valid = !(ir_q[7:4] inside {4'h8, 4'hA, 4'hC, 4'hD});
  assign op_dec   = op_valid ? ir_q[7:4] : OP_INVALID;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      ir_q       <= '0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      ir_q       <= ir_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // INVALID bypasses the ALU result and only steps the PC.
  always_comb begin
    cur_d = cur_q;
    ir_d  = ir_q;
    if (state_q == S_DECODE) ir_d = rom_data_i;
    if (state_q == S_EXEC) begin
      if (op_valid) begin
        cur_d = nxt;
      end else begin
        cur_d.pc = cur_q.pc + 4'd1;
      end
    end
  end

  always_comb begin
    busy_o     = (state_q != S_IDLE);
    rom_en_o   = (state_q == S_FETCH);
    rom_addr_o = cur_q.pc;
    retired_o  = (state_q == S_EXEC);
    opecode_o  = OP_INVALID;
    imm_o      = 4'd0;
    if (state_q == S_EXEC) begin
      opecode_o = op_dec;
      imm_o     = ir_q[3:0];
    end
  end
endmodule
